// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_pkg                                                       |
// | Description : Shared types and constants for the fetch-stage next-PC       |
// |               logic: redirect priority classes, default reset/exception   |
// |               addresses and the pending-redirect state enum.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pc_pkg;

  // Redirect priority class. The numeric order is the priority order, so a
  // plain magnitude compare decides whether one redirect may replace another.
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_BR   = 3'd1,
    CLS_J    = 3'd2,
    CLS_JR   = 3'd3,
    CLS_ERET = 3'd4,
    CLS_EXC  = 3'd5
  } redir_cls_e;

  // RUN: free fetch. HOLD: stalled with a redirect buffered.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

  localparam logic [31:0] c_RESET_PC_DFLT   = 32'h0040_0000;
  localparam logic [31:0] c_EXC_VECTOR_DFLT = 32'h0040_0004;

  // Word alignment check used for the address-error-on-load flag.
  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_target_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_target_sel                                                |
// | Description : Combinational priority encoder and target arithmetic for    |
// |               PC redirects (exc > eret > jr > j > br).                     |
// | Ports       : *_take_i   redirect requests                                 |
// |               br_base_i/br_offset_i, j_index_i, jr_target_i, epc_i operands |
// |               target_o   selected redirect address                         |
// |               cls_o      class of the selected redirect (CLS_NONE if none)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_target_sel
  import pc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = c_EXC_VECTOR_DFLT
) (
  input  logic        br_take_i,
  input  logic [31:0] br_base_i,
  input  logic [31:0] br_offset_i,
  input  logic        j_take_i,
  input  logic [25:0] j_index_i,
  input  logic        jr_take_i,
  input  logic [31:0] jr_target_i,
  input  logic        exc_take_i,
  input  logic        eret_take_i,
  input  logic [31:0] epc_i,
  output logic [31:0] target_o,
  output redir_cls_e  cls_o
);

  logic [31:0] w_br_target;
  logic [31:0] w_j_target;

  assign w_br_target = br_base_i + br_offset_i;
  // Jumps stay inside the 256 MB region of the delay slot.
  assign w_j_target  = {br_base_i[31:28], j_index_i, 2'b00};

  always_comb begin
    target_o = 32'h0000_0000;
    cls_o    = CLS_NONE;
    if (exc_take_i) begin
      target_o = EXC_VECTOR;
      cls_o    = CLS_EXC;
    end else if (eret_take_i) begin
      target_o = epc_i;
      cls_o    = CLS_ERET;
    end else if (jr_take_i) begin
      target_o = jr_target_i;
      cls_o    = CLS_JR;
    end else if (j_take_i) begin
      target_o = w_j_target;
      cls_o    = CLS_J;
    end else if (br_take_i) begin
      target_o = w_br_target;
      cls_o    = CLS_BR;
    end
  end

endmodule : pc_target_sel
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_next_unit                                                 |
// | Description : Fetch-stage program counter with next-PC selection and a    |
// |               one-entry buffer for redirects that arrive during a stall.  |
// | Ports       : clk, rst            clock, synchronous active-high reset     |
// |               stall_i             hold the current PC this cycle          |
// |               br/j/jr/exc/eret    redirect requests and operands           |
// |               pc_o                current fetch address                    |
// |               pc_plus4_o          pc_o + 4                                 |
// |               redirect_pending_o  a buffered redirect is waiting           |
// |               adel_o              pc_o is not word aligned                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = c_RESET_PC_DFLT,
  parameter logic [31:0] EXC_VECTOR = c_EXC_VECTOR_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_take_i,
  input  logic [31:0] br_base_i,
  input  logic [31:0] br_offset_i,
  input  logic        j_take_i,
  input  logic [25:0] j_index_i,
  input  logic        jr_take_i,
  input  logic [31:0] jr_target_i,
  input  logic        exc_take_i,
  input  logic        eret_take_i,
  input  logic [31:0] epc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        redirect_pending_o,
  output logic        adel_o
);

  pc_state_e   r_state_q;
  logic [31:0] r_pc_q;
  logic        r_adel_q;
  logic        r_pending_q;
  logic [31:0] r_lat_target_q;
  redir_cls_e  r_lat_cls_q;

  logic [31:0] w_sel_target;
  redir_cls_e  w_sel_cls;
  logic        w_any_redir;
  logic        w_new_wins;
  logic        w_pc_load;
  logic [31:0] w_pc_d;
  logic [31:0] w_pc_plus4;

  pc_target_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target_sel (
    .br_take_i   (br_take_i),
    .br_base_i   (br_base_i),
    .br_offset_i (br_offset_i),
    .j_take_i    (j_take_i),
    .j_index_i   (j_index_i),
    .jr_take_i   (jr_take_i),
    .jr_target_i (jr_target_i),
    .exc_take_i  (exc_take_i),
    .eret_take_i (eret_take_i),
    .epc_i       (epc_i),
    .target_o    (w_sel_target),
    .cls_o       (w_sel_cls)
  );

  assign w_any_redir = (w_sel_cls != CLS_NONE);
  assign w_pc_plus4  = r_pc_q + 32'd4;

  // A fresh redirect overrides the buffered one when its class is at least
  // as high; exceptions sit at the top so they always win.
  assign w_new_wins = w_any_redir && (w_sel_cls >= r_lat_cls_q);

  // Next PC: the PC moves only when fetch is not stalled.
  always_comb begin
    w_pc_load = 1'b0;
    w_pc_d    = r_pc_q;
    if (!stall_i) begin
      w_pc_load = 1'b1;
      if (r_state_q == ST_HOLD) begin
        w_pc_d = w_new_wins ? w_sel_target : r_lat_target_q;
      end else begin
        w_pc_d = w_any_redir ? w_sel_target : w_pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q      <= ST_RUN;
      r_pc_q         <= RESET_PC;
      r_adel_q       <= 1'b0;
      r_pending_q    <= 1'b0;
      r_lat_target_q <= 32'h0000_0000;
      r_lat_cls_q    <= CLS_NONE;
    end else begin
      if (w_pc_load) begin
        r_pc_q   <= w_pc_d;
        // Misaligned targets are still loaded; the flag lets the exception
        // logic report the fault against this PC.
        r_adel_q <= misaligned(w_pc_d);
      end

      if (r_state_q == ST_RUN) begin
        if (stall_i && w_any_redir) begin
          r_lat_target_q <= w_sel_target;
          r_lat_cls_q    <= w_sel_cls;
          r_pending_q    <= 1'b1;
          r_state_q      <= ST_HOLD;
        end
      end else begin
        if (stall_i) begin
          if (w_new_wins) begin
            r_lat_target_q <= w_sel_target;
            r_lat_cls_q    <= w_sel_cls;
          end
        end else begin
          // Buffered (or overriding) target was consumed by the PC load.
          r_lat_cls_q <= CLS_NONE;
          r_pending_q <= 1'b0;
          r_state_q   <= ST_RUN;
        end
      end
    end
  end

  assign pc_o               = r_pc_q;
  assign pc_plus4_o         = w_pc_plus4;
  assign redirect_pending_o = r_pending_q;
  assign adel_o             = r_adel_q;

endmodule : pc_next_unit
`default_nettype wire
